pipelined_reduction_tree: RTL and testbench

PIPELINED_REDUCTION_TREE -- requirements
Module: pipelined_reduction_tree

---
 rtl/pipelined_reduction_tree.sv | 194 +++++++++++++++++++
 tb/tb_pipelined_reduction_tree.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_reduction_tree.sv
// rtl/pipelined_reduction_tree.sv - pipelined add/sub/max/min reduction tree over N signed operands
//
// One register stage per tree level, each halving the number of live values.
// The last stage also narrows the wide sum back to DATA_WIDTH and registers
// result/out_index/overflow directly, so latency equals STAGES.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_valid      operand vector + op offered
//   in_ready      vector accepted this cycle (= pipeline enable)
//   inputs        N_INPUTS packed operands, element 0 in the low bits
//   op            00 add, 01 subtract, 10 max, 11 min
//   out_valid     result valid
//   out_ready     downstream accepts result
//   result        reduced value
//   out_index     operand index chosen by max/min, 0 for add/sub
//   overflow      add/sub full-precision result did not fit DATA_WIDTH
module pipelined_reduction_tree #(
    parameter int N_INPUTS   = 9,
    parameter int DATA_WIDTH = 16,
    parameter int SATURATE   = 1,
    localparam int STAGES    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
    localparam int IDX_W     = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
    localparam int ACC_W     = DATA_WIDTH + STAGES + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] inputs,
    input  logic [1:0]                     op,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          result,
    output logic [IDX_W-1:0]               out_index,
    output logic                           overflow
);

    // Stages that hold intermediate tree values (all but the output stage).
    localparam int PIPE = (STAGES > 1) ? STAGES - 1 : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic                    en;
    logic                    vld_q [STAGES];
    logic                    vld_d [STAGES];
    logic [1:0]              op_q  [PIPE];
    logic [1:0]              op_d  [PIPE];
    logic signed [ACC_W-1:0] val_q [PIPE][N_INPUTS];
    logic signed [ACC_W-1:0] val_d [PIPE][N_INPUTS];
    logic [IDX_W-1:0]        idx_q [PIPE][N_INPUTS];
    logic [IDX_W-1:0]        idx_d [PIPE][N_INPUTS];
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic [IDX_W-1:0]        index_q, index_d;
    logic                    ovf_q, ovf_d;

    logic signed [ACC_W-1:0] src_v [N_INPUTS];
    logic [IDX_W-1:0]        src_i [N_INPUTS];
    logic signed [ACC_W-1:0] dst_v [N_INPUTS];
    logic [IDX_W-1:0]        dst_i [N_INPUTS];
    logic signed [ACC_W-1:0] a, b;
    logic [1:0]              s_op;
    int                      src_cnt, sp, lo, hi;

    assign en        = !vld_q[STAGES-1] || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_q[STAGES-1];
    assign result    = result_q;
    assign out_index = index_q;
    assign overflow  = ovf_q;

    always_comb begin
        for (int s = 0; s < STAGES; s++) vld_d[s] = 1'b0;
        for (int s = 0; s < PIPE; s++) begin
            op_d[s] = 2'b00;
            for (int j = 0; j < N_INPUTS; j++) begin
                val_d[s][j] = '0;
                idx_d[s][j] = '0;
            end
        end
        for (int k = 0; k < N_INPUTS; k++) begin
            src_v[k] = '0;
            src_i[k] = '0;
            dst_v[k] = '0;
            dst_i[k] = '0;
        end
        result_d = result_q;
        index_d  = index_q;
        ovf_d    = ovf_q;
        a        = '0;
        b        = '0;
        s_op     = 2'b00;
        src_cnt  = 0;
        sp       = 0;
        lo       = 0;
        hi       = 0;

        for (int s = 0; s < STAGES; s++) begin
            sp       = (s > 0) ? s - 1 : 0;
            // Number of live values feeding this level.
            src_cnt  = (N_INPUTS + (1 << s) - 1) >> s;
            s_op     = (s == 0) ? op : op_q[sp];
            vld_d[s] = (s == 0) ? in_valid : vld_q[sp];

            for (int k = 0; k < N_INPUTS; k++) begin
                if (s == 0) begin
                    src_v[k] = {{(ACC_W-DATA_WIDTH){inputs[k*DATA_WIDTH+DATA_WIDTH-1]}},
                                inputs[k*DATA_WIDTH +: DATA_WIDTH]};
                    // Subtract is inputs[0] minus the sum of the rest.
                    if (op == 2'b01 && k > 0) src_v[k] = -src_v[k];
                    src_i[k] = IDX_W'(k);
                end else begin
                    src_v[k] = val_q[sp][k];
                    src_i[k] = idx_q[sp][k];
                end
            end

            for (int j = 0; j < N_INPUTS; j++) begin
                dst_v[j] = '0;
                dst_i[j] = '0;
                lo = (2*j < N_INPUTS) ? 2*j : N_INPUTS - 1;
                hi = (2*j + 1 < N_INPUTS) ? 2*j + 1 : N_INPUTS - 1;
                if (2*j + 1 < src_cnt) begin
                    a = src_v[lo];
                    b = src_v[hi];
                    // The left element always carries the lower index, so a
                    // strict compare makes ties keep the lower index.
                    case (s_op)
                        2'b10: begin
                            dst_v[j] = (b > a) ? b : a;
                            dst_i[j] = (b > a) ? src_i[hi] : src_i[lo];
                        end
                        2'b11: begin
                            dst_v[j] = (b < a) ? b : a;
                            dst_i[j] = (b < a) ? src_i[hi] : src_i[lo];
                        end
                        default: begin
                            dst_v[j] = a + b;
                            dst_i[j] = '0;
                        end
                    endcase
                end else if (2*j < src_cnt) begin
                    dst_v[j] = src_v[lo];
                    dst_i[j] = src_i[lo];
                end
            end

            if (s < STAGES - 1) begin
                op_d[s] = s_op;
                for (int j = 0; j < N_INPUTS; j++) begin
                    val_d[s][j] = dst_v[j];
                    idx_d[s][j] = dst_i[j];
                end
            end else if (vld_d[s]) begin
                a = dst_v[0];
                if (s_op[1]) begin
                    result_d = a[DATA_WIDTH-1:0];
                    index_d  = dst_i[0];
                    ovf_d    = 1'b0;
                end else begin
                    index_d = '0;
                    ovf_d   = (a > SAT_MAX) || (a < SAT_MIN);
                    if (SATURATE != 0 && a > SAT_MAX)
                        result_d = SAT_MAX[DATA_WIDTH-1:0];
                    else if (SATURATE != 0 && a < SAT_MIN)
                        result_d = SAT_MIN[DATA_WIDTH-1:0];
                    else
                        result_d = a[DATA_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) vld_q[s] <= 1'b0;
            result_q <= '0;
            index_q  <= '0;
            ovf_q    <= 1'b0;
        end else if (en) begin
            vld_q    <= vld_d;
            op_q     <= op_d;
            val_q    <= val_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            index_q  <= index_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipelined_reduction_tree.sv
// tb/tb_pipelined_reduction_tree.sv - directed vector bench for pipelined_reduction_tree
module tb_pipelined_reduction_tree;

    localparam int N  = 9;
    localparam int W  = 16;
    localparam int IW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             out_ready;
    logic [N*W-1:0]   inputs;
    logic [1:0]       op;
    logic             in_ready, out_valid, overflow;
    logic [W-1:0]     result;
    logic [IW-1:0]    out_index;
    logic             w_in_ready, w_out_valid, w_overflow;
    logic [W-1:0]     w_result;
    logic [IW-1:0]    w_out_index;

    always #5 clk = ~clk;

    pipelined_reduction_tree #(.N_INPUTS(N), .DATA_WIDTH(W), .SATURATE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .inputs(inputs), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_index(out_index), .overflow(overflow)
    );

    pipelined_reduction_tree #(.N_INPUTS(N), .DATA_WIDTH(W), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .inputs(inputs), .op(op), .out_valid(w_out_valid), .out_ready(out_ready),
        .result(w_result), .out_index(w_out_index), .overflow(w_overflow)
    );

    typedef struct {
        logic [N*W-1:0] vec;
        logic [1:0]     op;
        int             res;
        int             idx;
        int             ovf;
        int             wres;
    } vec_t;

    vec_t tbl [12];
    int   checks = 0;
    int   errors = 0;
    int   got_t [$];
    int   got_res [$];
    int   got_idx [$];
    int   exp_q [$];
    int   sent, popped, seen, prev_res, v;
    logic prev_stall;

    task automatic chk(input string nm, input logic signed [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] pk(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
        int e [N];
        logic [N*W-1:0] r;
        e = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
        r = '0;
        for (int k = 0; k < N; k++) r[k*W +: W] = e[k][W-1:0];
        return r;
    endfunction

    task automatic run_one(input vec_t t, input string tag);
        int lat;
        out_ready = 1'b1;
        inputs    = t.vec;
        op        = t.op;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            tick();
            lat++;
        end
        chk($sformatf("%s_latency", tag), lat, 4);
        chk($sformatf("%s_result", tag), $signed(result), t.res);
        chk($sformatf("%s_index", tag), out_index, t.idx);
        chk($sformatf("%s_overflow", tag), overflow, t.ovf);
        chk($sformatf("%s_wrap_result", tag), $signed(w_result), t.wres);
        chk($sformatf("%s_wrap_overflow", tag), w_overflow, t.ovf);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{pk(1, 2, 3, 4, 5, 6, 7, 8, 9), 2'b00, 45, 0, 0, 45};
        tbl[1]  = '{pk(100, 1, 2, 3, 4, 5, 6, 7, 8), 2'b01, 64, 0, 0, 64};
        tbl[2]  = '{pk(0, 0, 0, -32768, 0, 0, 0, 0, 0), 2'b01, 32767, 0, 1, -32768};
        tbl[3]  = '{pk(5, -3, 9, 9, 0, -7, 2, 9, 1), 2'b10, 9, 2, 0, 9};
        tbl[4]  = '{pk(5, -3, 9, 9, 0, -7, 2, 9, 1), 2'b11, -7, 5, 0, -7};
        tbl[5]  = '{pk(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768),
                    2'b00, -32768, 0, 1, -32768};
        tbl[6]  = '{pk(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767),
                    2'b00, 32767, 0, 1, 32759};
        tbl[7]  = '{pk(7, 7, 7, 7, 7, 7, 7, 7, 7), 2'b10, 7, 0, 0, 7};
        tbl[8]  = '{pk(-1, -2, -3, -4, -5, -6, -7, -8, -9), 2'b11, -9, 8, 0, -9};
        tbl[9]  = '{pk(-32768, 0, 0, 0, 0, 0, 0, 0, 0), 2'b01, -32768, 0, 0, -32768};
        tbl[10] = '{pk(32760, 1, 1, 1, 1, 1, 1, 1, 1), 2'b00, 32767, 0, 1, -32768};
        tbl[11] = '{pk(32760, 1, 1, 1, 1, 1, 1, 1, 0), 2'b00, 32767, 0, 0, 32767};

        // Reset, with a vector offered throughout that must be ignored.
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        op        = 2'b00;
        inputs    = pk(3, 3, 3, 3, 3, 3, 3, 3, 3);
        tick();
        tick();
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", $signed(result), 0);
        chk("reset_index", out_index, 0);
        chk("reset_overflow", overflow, 0);
        in_valid = 1'b0;
        rst      = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("reset_ignored_vectors", seen, 0);

        for (int i = 0; i < 12; i++) run_one(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back ops on consecutive cycles.
        got_t.delete();
        got_res.delete();
        got_idx.delete();
        out_ready = 1'b1;
        inputs    = pk(5, -3, 9, 9, 0, -7, 2, 9, 1);
        for (int t = 0; t < 12; t++) begin
            if (out_valid) begin
                got_t.push_back(t);
                got_res.push_back(int'($signed(result)));
                got_idx.push_back(int'(out_index));
            end
            in_valid = (t < 4);
            op       = 2'(t);
            tick();
        end
        in_valid = 1'b0;
        chk("b2b_count", got_t.size(), 4);
        if (got_t.size() == 4) begin
            chk("b2b_cycle0", got_t[0], 4);
            chk("b2b_cycle3", got_t[3], 7);
            chk("b2b_add", got_res[0], 25);
            chk("b2b_sub", got_res[1], -15);
            chk("b2b_max", got_res[2], 9);
            chk("b2b_max_index", got_idx[2], 2);
            chk("b2b_min", got_res[3], -7);
            chk("b2b_min_index", got_idx[3], 5);
        end

        // Stream 5 vectors with a 3-cycle downstream stall.
        exp_q.delete();
        sent       = 0;
        popped     = 0;
        prev_stall = 1'b0;
        prev_res   = 0;
        op         = 2'b00;
        for (int t = 0; t < 40 && popped < 5; t++) begin
            out_ready = !(t >= 5 && t < 8);
            in_valid  = (sent < 5);
            v         = sent + 1;
            inputs    = pk(v, v, v, v, v, v, v, v, v);
            #1;
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
            if (prev_stall) chk("stall_hold", $signed(result), prev_res);
            prev_stall = out_valid && !out_ready;
            prev_res   = int'($signed(result));
            if (in_valid && in_ready) begin
                exp_q.push_back(9 * (sent + 1));
                sent++;
            end
            if (out_valid && out_ready) begin
                chk("stall_nonempty", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("stall_order", $signed(result), exp_q.pop_front());
                popped++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("stall_sent", sent, 5);
        chk("stall_popped", popped, 5);
        chk("stall_no_duplicate", seen, 0);

        // Reset two cycles after acceptance discards the in-flight vector.
        out_ready = 1'b1;
        op        = 2'b00;
        inputs    = pk(1, 1, 1, 1, 1, 1, 1, 1, 1);
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst      = 1'b1;
        in_valid = 1'b1;
        inputs   = pk(100, 100, 100, 100, 100, 100, 100, 100, 100);
        #1;
        chk("rst_in_ready", in_ready, 1);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("rst_no_stale_out", seen, 0);
        chk("rst_result_cleared", $signed(result), 0);
        run_one(tbl[0], "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
